// File: rtl/gate_response_checker.sv
// gate_response_checker: samples a small combinational gate's input vector and
// output, builds the observed truth table, and compares every sample against
// the expected table. Reports pass/fail, error count, first failing vector and
// timeout.
module gate_response_checker #(
  parameter int                  N_IN    = 2,
  parameter logic [2**N_IN-1:0]  EXP_TT  = 4'b1000,
  parameter int                  TIMEOUT = 1000,
  parameter int                  ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 out_bit,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [2**N_IN-1:0]   seen_mask,
  output logic [2**N_IN-1:0]   obs_tt,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam int TT_W  = 2**N_IN;
  // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [TT_W-1:0]   hit;
  logic              mism;
  logic              covered;
  logic              expire;
  logic              start_run;

  // Per-sample decode; in_vec is only looked at when a sample is taken in
  // COLLECT so an undriven bus between samples cannot disturb state.
  always_comb begin
    hit  = '0;
    mism = 1'b0;
    if ((state == S_COLLECT) && sample_valid) begin
      hit[in_vec] = 1'b1;
      mism        = (out_bit != EXP_TT[in_vec]);
    end
  end

  // Run-level conditions: coverage including this edge's sample, timer expiry,
  // and a start that is actually honoured (not while collecting).
  always_comb begin
    covered   = &(seen_mask | hit);
    expire    = (TIMEOUT > 0) && (cyc_cnt == CNT_LAST);
    start_run = start && (state != S_COLLECT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; completion is checked before expiry so it wins a tie.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (covered)     state_nxt = S_DONE;
        else if (expire) state_nxt = S_DONE;
      end
      S_DONE:    if (start) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Result registers: cleared on an honoured start, updated by samples and the
  // cycle counter while collecting, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_mask       <= '0;
      obs_tt          <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      timeout         <= 1'b0;
      cyc_cnt         <= '0;
    end else if (start_run) begin
      seen_mask       <= '0;
      obs_tt          <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      timeout         <= 1'b0;
      cyc_cnt         <= '0;
    end else if (state == S_COLLECT) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (sample_valid) begin
        obs_tt[in_vec] <= out_bit;
        seen_mask      <= seen_mask | hit;
        if (mism) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= in_vec;
          end
        end
      end
      if (!covered && expire) timeout <= 1'b1;
    end
  end

  // Status outputs derived from registered state only.
  always_comb begin
    busy = (state == S_COLLECT);
    done = (state == S_DONE);
    pass = done & ~first_err_valid & ~timeout;
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed stimulus on two checker instances (default
// timeout and TIMEOUT=50), a run-level behavioural model compared every cycle,
// plus literal expectations at the end of each scenario.
module tb_gate_response_checker;

  localparam logic [3:0] EXP = 4'b1000;
  localparam int TO_P [2] = '{1000, 50};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t_start [2];
  logic       t_sv    [2];
  logic [1:0] t_vec   [2];
  logic       t_out   [2];

  logic       o_busy [2], o_done [2], o_pass [2], o_to [2], o_fev [2];
  logic [3:0] o_seen [2], o_obs [2];
  logic [7:0] o_err  [2];
  logic [1:0] o_fei  [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.N_IN(2), .EXP_TT(4'b1000), .TIMEOUT(1000), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(t_start[0]), .sample_valid(t_sv[0]),
    .in_vec(t_vec[0]), .out_bit(t_out[0]), .busy(o_busy[0]), .done(o_done[0]),
    .pass(o_pass[0]), .timeout(o_to[0]), .seen_mask(o_seen[0]), .obs_tt(o_obs[0]),
    .err_count(o_err[0]), .first_err_valid(o_fev[0]), .first_err_idx(o_fei[0])
  );

  gate_response_checker #(.N_IN(2), .EXP_TT(4'b1000), .TIMEOUT(50), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(t_start[1]), .sample_valid(t_sv[1]),
    .in_vec(t_vec[1]), .out_bit(t_out[1]), .busy(o_busy[1]), .done(o_done[1]),
    .pass(o_pass[1]), .timeout(o_to[1]), .seen_mask(o_seen[1]), .obs_tt(o_obs[1]),
    .err_count(o_err[1]), .first_err_valid(o_fev[1]), .first_err_idx(o_fei[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no run yet / reset, 1 = collecting, 2 = finished
  int       m_phase [2];
  int       m_cyc   [2];
  int       m_err   [2];
  bit [3:0] m_seen  [2];
  bit [3:0] m_obs   [2];
  bit       m_fev   [2];
  bit [1:0] m_fei   [2];
  bit       m_to    [2];
  bit       mdl_live = 1'b0;

  task automatic mdl_clear(input int i);
    m_cyc[i] = 0; m_err[i] = 0; m_seen[i] = '0; m_obs[i] = '0;
    m_fev[i] = 1'b0; m_fei[i] = '0; m_to[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mdl_clear(i);
        m_phase[i] = 0;
      end else if (m_phase[i] != 1) begin
        if (t_start[i]) begin
          mdl_clear(i);
          m_phase[i] = 1;
        end
      end else begin
        int k;
        m_cyc[i]++;
        if (t_sv[i]) begin
          k = int'(t_vec[i]);
          m_obs[i][k]  = t_out[i];
          m_seen[i][k] = 1'b1;
          if (t_out[i] != EXP[k]) begin
            m_err[i]++;
            if (!m_fev[i]) begin
              m_fev[i] = 1'b1;
              m_fei[i] = t_vec[i];
            end
          end
        end
        if (m_seen[i] == 4'hF) m_phase[i] = 2;
        else if (TO_P[i] > 0 && m_cyc[i] >= TO_P[i]) begin
          m_phase[i] = 2;
          m_to[i]    = 1'b1;
        end
      end
    end
    mdl_live = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mdl_live) begin
      for (int i = 0; i < 2; i++) begin
        int e_err;
        e_err = (m_err[i] > 255) ? 255 : m_err[i];
        chk($sformatf("busy[%0d]", i), 32'(o_busy[i]), 32'(m_phase[i] == 1));
        chk($sformatf("done[%0d]", i), 32'(o_done[i]), 32'(m_phase[i] == 2));
        chk($sformatf("pass[%0d]", i), 32'(o_pass[i]),
            32'(m_phase[i] == 2 && !m_fev[i] && !m_to[i]));
        chk($sformatf("timeout[%0d]", i), 32'(o_to[i]), 32'(m_to[i]));
        chk($sformatf("seen[%0d]", i), 32'(o_seen[i]), 32'(m_seen[i]));
        chk($sformatf("obs[%0d]", i), 32'(o_obs[i]), 32'(m_obs[i]));
        chk($sformatf("err[%0d]", i), 32'(o_err[i]), 32'(e_err));
        chk($sformatf("fev[%0d]", i), 32'(o_fev[i]), 32'(m_fev[i]));
        chk($sformatf("fei[%0d]", i), 32'(o_fei[i]), 32'(m_fei[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i);
    t_start[i] = 1'b1;
    @(negedge clk);
    t_start[i] = 1'b0;
  endtask

  task automatic sample(input int i, input logic [1:0] v, input logic b);
    t_sv[i] = 1'b1; t_vec[i] = v; t_out[i] = b;
    @(negedge clk);
    t_sv[i] = 1'b0; t_vec[i] = 2'bxx; t_out[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      t_start[i] = 1'b0; t_sv[i] = 1'b0; t_vec[i] = 2'bxx; t_out[i] = 1'b0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("reset busy", 32'(o_busy[0]), 32'd0);
    chk("reset done", 32'(o_done[1]), 32'd0);
    chk("reset err", 32'(o_err[0]), 32'd0);

    // AND sweep, samples 100 cycles apart.
    pulse_start(0);
    sample(0, 2'd0, 1'b0); idle(99);
    sample(0, 2'd1, 1'b0); idle(99);
    sample(0, 2'd2, 1'b0); idle(99);
    chk("and done before last", 32'(o_done[0]), 32'd0);
    sample(0, 2'd3, 1'b1);
    chk("and done", 32'(o_done[0]), 32'd1);
    chk("and pass", 32'(o_pass[0]), 32'd1);
    chk("and err", 32'(o_err[0]), 32'd0);
    chk("and obs", 32'(o_obs[0]), 32'h8);
    chk("and seen", 32'(o_seen[0]), 32'hF);

    // OR-like faulty gate.
    pulse_start(0);
    sample(0, 2'd0, 1'b0); sample(0, 2'd1, 1'b1);
    sample(0, 2'd2, 1'b1); sample(0, 2'd3, 1'b1);
    chk("or done", 32'(o_done[0]), 32'd1);
    chk("or err", 32'(o_err[0]), 32'd2);
    chk("or fei", 32'(o_fei[0]), 32'd1);
    chk("or obs", 32'(o_obs[0]), 32'hE);
    chk("or pass", 32'(o_pass[0]), 32'd0);

    // Duplicates and out-of-order.
    pulse_start(0);
    sample(0, 2'd3, 1'b1); sample(0, 2'd3, 1'b0);
    sample(0, 2'd0, 1'b0); sample(0, 2'd2, 1'b0);
    chk("dup done early", 32'(o_done[0]), 32'd0);
    sample(0, 2'd1, 1'b0);
    chk("dup done", 32'(o_done[0]), 32'd1);
    chk("dup err", 32'(o_err[0]), 32'd1);
    chk("dup fei", 32'(o_fei[0]), 32'd3);
    chk("dup obs3", 32'(o_obs[0][3]), 32'd0);

    // Timeout instance: two samples only, expiry after 50 COLLECT cycles.
    pulse_start(1);
    sample(1, 2'd0, 1'b0); sample(1, 2'd1, 1'b0);
    idle(47);
    chk("to busy at 50th cycle", 32'(o_busy[1]), 32'd1);
    idle(1);
    chk("to done", 32'(o_done[1]), 32'd1);
    chk("to timeout", 32'(o_to[1]), 32'd1);
    chk("to seen", 32'(o_seen[1]), 32'h3);
    chk("to pass", 32'(o_pass[1]), 32'd0);

    // Covering sample lands on the expiring edge: completion wins.
    pulse_start(1);
    sample(1, 2'd0, 1'b0); sample(1, 2'd1, 1'b0); sample(1, 2'd2, 1'b0);
    idle(46);
    chk("tie busy", 32'(o_busy[1]), 32'd1);
    sample(1, 2'd3, 1'b1);
    chk("tie done", 32'(o_done[1]), 32'd1);
    chk("tie timeout", 32'(o_to[1]), 32'd0);
    chk("tie pass", 32'(o_pass[1]), 32'd1);

    // Reset mid-COLLECT, then samples without start are ignored.
    pulse_start(0);
    sample(0, 2'd0, 1'b0); sample(0, 2'd1, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst busy", 32'(o_busy[0]), 32'd0);
    chk("rst seen", 32'(o_seen[0]), 32'd0);
    chk("rst err", 32'(o_err[0]), 32'd0);
    chk("rst fev", 32'(o_fev[0]), 32'd0);
    chk("rst done1", 32'(o_done[1]), 32'd0);
    sample(0, 2'd0, 1'b1); sample(0, 2'd1, 1'b1);
    chk("idle seen", 32'(o_seen[0]), 32'd0);
    chk("idle err", 32'(o_err[0]), 32'd0);

    // Failing run, then restart from DONE with a start pulse inside COLLECT.
    pulse_start(0);
    sample(0, 2'd0, 1'b0); sample(0, 2'd1, 1'b1);
    sample(0, 2'd2, 1'b1); sample(0, 2'd3, 1'b1);
    chk("fail pass", 32'(o_pass[0]), 32'd0);
    pulse_start(0);
    sample(0, 2'd0, 1'b0); sample(0, 2'd1, 1'b0);
    pulse_start(0);
    sample(0, 2'd2, 1'b0); sample(0, 2'd3, 1'b1);
    chk("restart done", 32'(o_done[0]), 32'd1);
    chk("restart err", 32'(o_err[0]), 32'd0);
    chk("restart fev", 32'(o_fev[0]), 32'd0);
    chk("restart pass", 32'(o_pass[0]), 32'd1);

    // Error counter saturation.
    pulse_start(0);
    repeat (260) sample(0, 2'd0, 1'b1);
    chk("sat err", 32'(o_err[0]), 32'd255);
    chk("sat busy", 32'(o_busy[0]), 32'd1);
    sample(0, 2'd1, 1'b0); sample(0, 2'd2, 1'b0); sample(0, 2'd3, 1'b1);
    chk("sat done", 32'(o_done[0]), 32'd1);
    chk("sat err hold", 32'(o_err[0]), 32'd255);
    chk("sat fei", 32'(o_fei[0]), 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable receive-side counterpart to the gate stimulus benches: samples the input vector applied to a small combinational gate together with its output, builds the observed truth table, and compares each sample against an expected truth table.
- Sits beside the gate under test in on-chip self-test; the stimulus source only strobes sample_valid once per applied vector.
- Reports pass/fail, error count, first failing vector and timeout.

Parameters:
- N_IN, 2, number of gate inputs; truth table has 2**N_IN entries.
- EXP_TT, 4'b1000, expected output per input combination; bit k = expected F when in_vec == k (default = 2-input AND, in_vec = {A,B}).
- TIMEOUT, 1000, max cycles in COLLECT before forced finish; 0 disables the timeout.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new collection run (honoured in IDLE or DONE only)
- sample_valid  input  1  in_vec/out_bit are settled and must be sampled this cycle
- in_vec  input  N_IN  input combination applied to the gate
- out_bit  input  1  gate output for in_vec
- busy  output  1  high in COLLECT
- done  output  1  high in DONE (level, held until start or rst)
- pass  output  1  done and no mismatch and no timeout
- timeout  output  1  run ended by TIMEOUT expiry
- seen_mask  output  2**N_IN  bit k set once vector k has been sampled this run
- obs_tt  output  2**N_IN  last observed out_bit per vector
- err_count  output  ERR_W  mismatch count, saturates at all-ones
- first_err_valid  output  1  at least one mismatch recorded
- first_err_idx  output  N_IN  in_vec of first mismatch

Behaviour:
- Reset: clk edge with rst=1 → state IDLE; every output 0. rst wins over all other inputs, including mid-COLLECT.
- States: IDLE, COLLECT, DONE.
- IDLE: start=1 → COLLECT next cycle; same edge clears seen_mask, obs_tt, err_count, first_err_*, timeout and the cycle counter. sample_valid ignored in IDLE.
- COLLECT, each edge with sample_valid=1, k = in_vec:
  - obs_tt[k] <= out_bit; seen_mask[k] <= 1.
  - If out_bit != EXP_TT[k]: err_count increments, saturating. If first_err_valid=0, first_err_idx <= k and first_err_valid <= 1.
  - Repeated vectors are re-compared and counted again; obs_tt holds the latest value.
- Completion: when seen_mask including the current sample is all ones, go to DONE on that same edge. done=1 on the following cycle. Latency from the final covering sample to done is 1 cycle.
- Timeout (TIMEOUT>0): the cycle counter increments every COLLECT cycle. If it reaches TIMEOUT-1 without completion, go to DONE with timeout <= 1.
  - If completion and timeout occur on the same edge, completion wins and timeout stays 0.
  - A sample on the expiring edge is still recorded.
- start in COLLECT is ignored.
- DONE: outputs are held. sample_valid is ignored. start=1 → COLLECT with the same clears as from IDLE.
- pass = done & ~first_err_valid & ~timeout, registered or derived combinationally from registered state; no combinational path from inputs.
- busy = (state==COLLECT).
- X on in_vec when sample_valid=0 must not affect state.

Test Plan:
- AND sweep, default params: start, then samples (in_vec,out_bit) = (00,0),(01,0),(10,0),(11,1), 100 cycles apart → done=1 one cycle after the 4th sample, pass=1, err_count=0, obs_tt=4'b1000, seen_mask=4'b1111.
- Faulty OR-like gate: samples (00,0),(01,1),(10,1),(11,1) → err_count=2, first_err_idx=2'b01, obs_tt=4'b1110, pass=0, done=1.
- Duplicates and out-of-order: (11,1),(11,0),(00,0),(10,0),(01,0) → done only after the 5th sample, err_count=1, first_err_idx=2'b11, obs_tt[3]=0.
- Timeout with TIMEOUT=50: only (00,0),(01,0) supplied → done=1 and timeout=1 after exactly 50 COLLECT cycles, seen_mask=4'b0011, pass=0. Final sample on the expiring edge completes coverage → timeout=0, pass=1.
- rst=1 asserted mid-COLLECT after 2 samples → next cycle all outputs 0, state IDLE. Samples without start are ignored (seen_mask stays 0).
- Restart from DONE after a failing run: start, then a clean AND sweep → err_count=0, first_err_valid=0, pass=1. start pulsed during COLLECT has no effect.
